// File: rtl/scan_matrix_pkg.sv
// Shared constants and types for the PS/2 set-2 to keyboard-matrix tracker.
// Defining SCAN_MATRIX_EXT_EN enables E0-prefixed (extended) key support.
package scan_matrix_pkg;

  // Lookup code layout: [7] shift toggle, [6:4] row, [3] unused, [2:0] column
  localparam logic [7:0] UNMAPPED     = 8'hFF;
  localparam int         CODE_TOGGLE  = 7;
  localparam int         CODE_ROW_LSB = 4;
  localparam int         CODE_COL_LSB = 0;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

`ifdef SCAN_MATRIX_EXT_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK
  } prefix_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_DISCARD
  } prefix_state_e;
`endif

  typedef struct packed {
    logic       valid;
    logic [7:0] scancode;
`ifdef SCAN_MATRIX_EXT_EN
    logic       ext;
`endif
    logic [2:0] row;
    logic [2:0] col;
    logic       toggle;
  } slot_t;

endpackage

// File: rtl/scan_matrix_rom.sv
// Combinational key lookup: (scancode, ext, shift) -> {toggle, row, col} code.
// The ext input is tied low by the tracker unless SCAN_MATRIX_EXT_EN is defined.
module scan_matrix_rom
  import scan_matrix_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] code
);

  always_comb begin
    code = UNMAPPED;
    case ({ext, scancode})
      9'h01C: code = 8'h41;
      9'h032: code = 8'h42;
      9'h021: code = 8'h43;
      9'h023: code = 8'h44;
      9'h024: code = 8'h45;
      9'h02B: code = 8'h46;
      9'h034: code = 8'h47;
      9'h01B: code = 8'h53;
      9'h029: code = 8'h13;
      9'h016: code = 8'h31;
      // Shift+2 lands on a different key that needs the host shift inverted
      9'h01E: code = shift ? 8'hC0 : 8'h32;
      9'h052: code = 8'h40;
      9'h05A: code = 8'h12;
      9'h066: code = 8'h03;
      9'h076: code = 8'h77;
      9'h075: code = 8'h25;
      9'h04E: code = 8'hB5;
      9'h175: code = 8'h05;
      9'h172: code = 8'h07;
      9'h16B: code = 8'h04;
      9'h174: code = 8'h06;
      9'h16C: code = 8'h00;
      9'h171: code = 8'h02;
      default: code = UNMAPPED;
    endcase
  end

endmodule

// File: rtl/scan_matrix_tracker.sv
// Tracks held PS/2 keys in a small slot table and presents them as a scanned
// keyboard matrix. SCAN_MATRIX_EXT_EN enables extended (E0) keys.
module scan_matrix_tracker
  import scan_matrix_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int SLOTS = 4
) (
  input  logic                 c,
  input  logic                 reset,
  input  logic [7:0]           scancode,
  input  logic                 scancode_valid,
  input  logic [ROWS-1:0]      rowsel,
  output logic [COLS-1:0]      colq,
  output logic [ROWS*COLS-1:0] matrix,
  output logic                 qshift,
  output logic                 qerror
);

  logic [7:0]           byte_q, byte_d;
  logic                 strobe_q, strobe_d;
  prefix_state_e        state_q, state_d;
  slot_t                slots_q [SLOTS];
  slot_t                slots_d [SLOTS];
  logic                 last_valid_q, last_valid_d;
  logic [2:0]           last_idx_q, last_idx_d;
  logic                 shift_held_q, shift_held_d;
  logic [ROWS*COLS-1:0] matrix_q, matrix_d;
  logic                 qshift_q, qshift_d;
  logic                 qerror_q, qerror_d;

  logic             key_ext;
  logic [7:0]       code;
  logic             mapped;
  logic             is_shift;
  logic             is_make;
  logic             is_break;
  logic [SLOTS-1:0] match;
  logic             free_found;
  logic [2:0]       free_idx;
  slot_t            new_slot;
  logic             last_toggle;

`ifdef SCAN_MATRIX_EXT_EN
  assign key_ext = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
`else
  assign key_ext = 1'b0;
`endif

  scan_matrix_rom u_rom (
    .scancode (byte_q),
    .ext      (key_ext),
    .shift    (shift_held_q),
    .code     (code)
  );

  assign mapped = (code != UNMAPPED)
               && (int'(code[CODE_ROW_LSB +: 3]) < ROWS)
               && (int'(code[CODE_COL_LSB +: 3]) < COLS);
  assign is_shift = !key_ext && ((byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT));

  always_comb begin
    byte_d   = scancode;
    strobe_d = scancode_valid;
  end

  // Slot matching and lowest-free-slot search for the byte being processed
  always_comb begin
    match      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
`ifdef SCAN_MATRIX_EXT_EN
      match[i] = slots_q[i].valid && (slots_q[i].scancode == byte_q) && (slots_q[i].ext == key_ext);
`else
      match[i] = slots_q[i].valid && (slots_q[i].scancode == byte_q);
`endif
      if (!slots_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
    new_slot          = '0;
    new_slot.valid    = 1'b1;
    new_slot.scancode = byte_q;
`ifdef SCAN_MATRIX_EXT_EN
    new_slot.ext      = key_ext;
`endif
    new_slot.row      = code[CODE_ROW_LSB +: 3];
    new_slot.col      = code[CODE_COL_LSB +: 3];
    new_slot.toggle   = code[CODE_TOGGLE];
  end

  always_comb begin
    state_d      = state_q;
    slots_d      = slots_q;
    last_valid_d = last_valid_q;
    last_idx_d   = last_idx_q;
    shift_held_d = shift_held_q;
    qerror_d     = 1'b0;
    is_make      = 1'b0;
    is_break     = 1'b0;

    if (strobe_q) begin
      case (state_q)
`ifdef SCAN_MATRIX_EXT_EN
        ST_IDLE: begin
          if (byte_q == SC_E0)      state_d = ST_EXT;
          else if (byte_q == SC_F0) state_d = ST_BRK;
          else                      is_make = 1'b1;
        end
        ST_EXT: begin
          if (byte_q == SC_F0) begin
            state_d = ST_EXTBRK;
          end else begin
            is_make = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          is_break = 1'b1;
          state_d  = ST_IDLE;
        end
`else
        ST_IDLE: begin
          if (byte_q == SC_E0)      state_d = ST_DISCARD;
          else if (byte_q == SC_F0) state_d = ST_BRK;
          else                      is_make = 1'b1;
        end
        ST_BRK: begin
          is_break = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_DISCARD: state_d = ST_IDLE;
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    if (is_make) begin
      if (is_shift) begin
        shift_held_d = 1'b1;
      end else if (!mapped) begin
        qerror_d = 1'b1;
      end else if (match == '0) begin
        if (free_found) begin
          for (int i = 0; i < SLOTS; i++) begin
            if (free_idx == 3'(i)) slots_d[i] = new_slot;
          end
          last_valid_d = 1'b1;
          last_idx_d   = free_idx;
        end else begin
          qerror_d = 1'b1;
        end
      end
    end

    if (is_break) begin
      if (is_shift) begin
        shift_held_d = 1'b0;
      end else begin
        for (int i = 0; i < SLOTS; i++) begin
          if (match[i]) begin
            slots_d[i].valid = 1'b0;
            if (last_valid_q && (last_idx_q == 3'(i))) last_valid_d = 1'b0;
          end
        end
      end
    end
  end

  // Several slots may share a row/col; the bit stays up while any holds it
  always_comb begin
    matrix_d    = '0;
    last_toggle = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < COLS; j++) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (slots_q[i].valid && (slots_q[i].row == 3'(r)) && (slots_q[i].col == 3'(j)))
            matrix_d[r*COLS + j] = 1'b1;
        end
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (last_valid_q && (last_idx_q == 3'(i))) last_toggle = slots_q[i].toggle;
    end
    qshift_d = shift_held_q ^ last_toggle;
  end

  always_comb begin
    colq = '1;
    for (int j = 0; j < COLS; j++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!rowsel[r] && matrix_q[r*COLS + j]) colq[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge c) begin
    if (reset) begin
      byte_q       <= '0;
      strobe_q     <= 1'b0;
      state_q      <= ST_IDLE;
      for (int i = 0; i < SLOTS; i++) slots_q[i] <= '0;
      last_valid_q <= 1'b0;
      last_idx_q   <= '0;
      shift_held_q <= 1'b0;
      matrix_q     <= '0;
      qshift_q     <= 1'b0;
      qerror_q     <= 1'b0;
    end else begin
      byte_q       <= byte_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      slots_q      <= slots_d;
      last_valid_q <= last_valid_d;
      last_idx_q   <= last_idx_d;
      shift_held_q <= shift_held_d;
      matrix_q     <= matrix_d;
      qshift_q     <= qshift_d;
      qerror_q     <= qerror_d;
    end
  end

  assign matrix = matrix_q;
  assign qshift = qshift_q;
  assign qerror = qerror_q;

endmodule

// File: tb/tb_scan_matrix_tracker.sv
// Directed and randomized bench for scan_matrix_tracker with a behavioural
// key-tracking model; honours SCAN_MATRIX_EXT_EN when defined.
module tb_scan_matrix_tracker;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int SLOTS = 4;
`ifdef SCAN_MATRIX_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic                 c = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           scancode = 8'h00;
  logic                 scancode_valid = 1'b0;
  logic [ROWS-1:0]      rowsel = '1;
  logic [COLS-1:0]      colq;
  logic [ROWS*COLS-1:0] matrix;
  logic                 qshift;
  logic                 qerror;

  int total = 0;
  int bad   = 0;

  always #5 c = ~c;

  scan_matrix_tracker #(.ROWS(ROWS), .COLS(COLS), .SLOTS(SLOTS)) dut (
    .c              (c),
    .reset          (reset),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .rowsel         (rowsel),
    .colq           (colq),
    .matrix         (matrix),
    .qshift         (qshift),
    .qerror         (qerror)
  );

  // Key table: extended flag, scancode, code without shift, code with shift
  typedef struct packed {
    logic       ext;
    logic [7:0] sc;
    logic [7:0] plain;
    logic [7:0] shifted;
  } key_t;

  key_t keymap [$] = '{
    '{1'b0, 8'h1C, 8'h41, 8'h41}, '{1'b0, 8'h32, 8'h42, 8'h42},
    '{1'b0, 8'h21, 8'h43, 8'h43}, '{1'b0, 8'h23, 8'h44, 8'h44},
    '{1'b0, 8'h24, 8'h45, 8'h45}, '{1'b0, 8'h2B, 8'h46, 8'h46},
    '{1'b0, 8'h34, 8'h47, 8'h47}, '{1'b0, 8'h1B, 8'h53, 8'h53},
    '{1'b0, 8'h29, 8'h13, 8'h13}, '{1'b0, 8'h16, 8'h31, 8'h31},
    '{1'b0, 8'h1E, 8'h32, 8'hC0}, '{1'b0, 8'h52, 8'h40, 8'h40},
    '{1'b0, 8'h5A, 8'h12, 8'h12}, '{1'b0, 8'h66, 8'h03, 8'h03},
    '{1'b0, 8'h76, 8'h77, 8'h77}, '{1'b0, 8'h75, 8'h25, 8'h25},
    '{1'b0, 8'h4E, 8'hB5, 8'hB5}, '{1'b1, 8'h75, 8'h05, 8'h05},
    '{1'b1, 8'h72, 8'h07, 8'h07}, '{1'b1, 8'h6B, 8'h04, 8'h04},
    '{1'b1, 8'h74, 8'h06, 8'h06}, '{1'b1, 8'h6C, 8'h00, 8'h00},
    '{1'b1, 8'h71, 8'h02, 8'h02}
  };

  logic [7:0] pool [$] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h1B, 8'h29, 8'h16,
    8'h1E, 8'h52, 8'h5A, 8'h66, 8'h76, 8'h75, 8'h4E, 8'h72, 8'h6B, 8'h71,
    8'h12, 8'h59, 8'h0E, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0
  };

  // Model: held keys per slot, the most recently pressed slot, shift and prefix
  bit         m_valid [SLOTS];
  logic [7:0] m_sc    [SLOTS];
  bit         m_ext   [SLOTS];
  int         m_row   [SLOTS];
  int         m_col   [SLOTS];
  bit         m_tog   [SLOTS];
  int         m_last;
  bit         m_shift, pend_e0, pend_f0, discard;

  function automatic logic [7:0] ref_code(input logic [7:0] sc, input bit ext, input bit sh);
    for (int k = 0; k < keymap.size(); k++) begin
      if (keymap[k].ext == ext && keymap[k].sc == sc)
        return sh ? keymap[k].shifted : keymap[k].plain;
    end
    return 8'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
    m_last = -1; m_shift = 0; pend_e0 = 0; pend_f0 = 0; discard = 0;
  endtask

  task automatic model_make(input logic [7:0] sc, input bit ext, output bit err);
    logic [7:0] code;
    int row, col, free;
    err = 0;
    if (!ext && (sc == 8'h12 || sc == 8'h59)) begin
      m_shift = 1;
      return;
    end
    code = ref_code(sc, ext, m_shift);
    row  = int'(code[6:4]);
    col  = int'(code[2:0]);
    if (code == 8'hFF || row >= ROWS || col >= COLS) begin
      err = 1;
      return;
    end
    for (int i = 0; i < SLOTS; i++)
      if (m_valid[i] && m_sc[i] == sc && m_ext[i] == ext) return;
    free = -1;
    for (int i = 0; i < SLOTS; i++)
      if (!m_valid[i] && free < 0) free = i;
    if (free < 0) begin
      err = 1;
      return;
    end
    m_valid[free] = 1; m_sc[free] = sc; m_ext[free] = ext;
    m_row[free] = row; m_col[free] = col; m_tog[free] = code[7];
    m_last = free;
  endtask

  task automatic model_break(input logic [7:0] sc, input bit ext);
    if (!ext && (sc == 8'h12 || sc == 8'h59)) begin
      m_shift = 0;
      return;
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (m_valid[i] && m_sc[i] == sc && m_ext[i] == ext) begin
        m_valid[i] = 0;
        if (m_last == i) m_last = -1;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output bit err);
    err = 0;
    if (discard) begin
      discard = 0;
    end else if (pend_f0) begin
      model_break(b, pend_e0);
      pend_f0 = 0; pend_e0 = 0;
    end else if (b == 8'hE0 && !pend_e0) begin
      if (EXT_EN) pend_e0 = 1;
      else        discard = 1;
    end else if (b == 8'hF0) begin
      pend_f0 = 1;
    end else begin
      model_make(b, pend_e0, err);
      pend_e0 = 0;
    end
  endtask

  function automatic logic [63:0] exp_matrix();
    logic [63:0] m = '0;
    for (int i = 0; i < SLOTS; i++)
      if (m_valid[i]) m[m_row[i]*COLS + m_col[i]] = 1'b1;
    return m;
  endfunction

  function automatic bit exp_qshift();
    return m_shift ^ ((m_last >= 0) ? m_tog[m_last] : 1'b0);
  endfunction

  function automatic logic [COLS-1:0] exp_colq(input logic [63:0] m, input logic [ROWS-1:0] sel);
    logic [COLS-1:0] q = '1;
    for (int j = 0; j < COLS; j++)
      for (int r = 0; r < ROWS; r++)
        if (!sel[r] && m[r*COLS + j]) q[j] = 1'b0;
    return q;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One byte: strobe before edge N, qerror visible after N+1, matrix after N+2
  task automatic applyStimulus(input logic [7:0] b);
    logic [63:0] prev_m;
    bit          prev_q, err;
    prev_m = exp_matrix();
    prev_q = exp_qshift();
    @(negedge c);
    scancode       = b;
    scancode_valid = 1'b1;
    rowsel         = ROWS'($urandom);
    @(negedge c);
    scancode_valid = 1'b0;
    scancode       = 8'($urandom);
    model_byte(b, err);
    @(negedge c);
    checkOutput("qerror_pulse", 64'(qerror), 64'(err));
    checkOutput("matrix_latency", 64'(matrix), prev_m);
    checkOutput("qshift_latency", 64'(qshift), 64'(prev_q));
    @(negedge c);
    checkOutput("matrix", 64'(matrix), exp_matrix());
    checkOutput("qshift", 64'(qshift), 64'(exp_qshift()));
    checkOutput("qerror_idle", 64'(qerror), 64'(0));
    checkOutput("colq", 64'(colq), 64'(exp_colq(exp_matrix(), rowsel)));
  endtask

  // Reset with a coincident strobe; the strobed byte must be lost
  task automatic doReset();
    @(negedge c);
    reset          = 1'b1;
    scancode       = 8'h1C;
    scancode_valid = 1'b1;
    @(negedge c);
    scancode_valid = 1'b0;
    @(negedge c);
    reset = 1'b0;
    model_reset();
    checkOutput("reset_matrix", 64'(matrix), 64'(0));
    checkOutput("reset_qshift", 64'(qshift), 64'(0));
    checkOutput("reset_qerror", 64'(qerror), 64'(0));
    checkOutput("reset_colq", 64'(colq), 64'({COLS{1'b1}}));
    @(negedge c);
    @(negedge c);
    checkOutput("reset_no_capture", 64'(matrix), 64'(0));
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    $display("[TB] start, extended keys %0s", EXT_EN ? "enabled" : "disabled");
    doReset();

    applyStimulus(8'h1C);
    checkOutput("make_1C_bit", 64'(matrix[4*8+1]), 64'(1));
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    checkOutput("break_1C_bit", 64'(matrix[4*8+1]), 64'(0));

    applyStimulus(8'h12); applyStimulus(8'h1E);
    checkOutput("shift2_bit", 64'(matrix[4*8+0]), 64'(1));
    checkOutput("shift2_qshift", 64'(qshift), 64'(0));
    applyStimulus(8'hF0); applyStimulus(8'h12);
    checkOutput("shift_released_bit", 64'(matrix[4*8+0]), 64'(1));
    checkOutput("shift_released_qshift", 64'(qshift), 64'(1));
    applyStimulus(8'hF0); applyStimulus(8'h1E);
    checkOutput("break_1E_bit", 64'(matrix[4*8+0]), 64'(0));

    applyStimulus(8'h12); applyStimulus(8'h1E); applyStimulus(8'h52);
    applyStimulus(8'hF0); applyStimulus(8'h12);
    applyStimulus(8'hF0); applyStimulus(8'h1E);
    checkOutput("shared_bit_held", 64'(matrix[4*8+0]), 64'(1));
    applyStimulus(8'hF0); applyStimulus(8'h52);
    checkOutput("shared_bit_clear", 64'(matrix[4*8+0]), 64'(0));

    applyStimulus(8'h1C); applyStimulus(8'h1B); applyStimulus(8'h23); applyStimulus(8'h2B);
    applyStimulus(8'h34);
    checkOutput("overflow_dropped", 64'(matrix[4*8+7]), 64'(0));
    applyStimulus(8'hF0); applyStimulus(8'h1C); applyStimulus(8'h34);
    checkOutput("overflow_retry", 64'(matrix[4*8+7]), 64'(1));
    applyStimulus(8'hF0); applyStimulus(8'h1B); applyStimulus(8'hF0); applyStimulus(8'h23);
    applyStimulus(8'hF0); applyStimulus(8'h2B); applyStimulus(8'hF0); applyStimulus(8'h34);

    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    checkOutput("repeat_cleared", 64'(matrix), 64'(0));

    applyStimulus(8'hE0); applyStimulus(8'h75);
    checkOutput("ext_cursor_bit", 64'(matrix[5]), 64'(EXT_EN));
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    checkOutput("ext_cursor_clear", 64'(matrix[5]), 64'(0));
    applyStimulus(8'hF0); applyStimulus(8'h75);

    applyStimulus(8'h29);
    @(negedge c);
    rowsel = 8'hFD;
    #1;
    checkOutput("rowsel_colq", 64'(colq), 64'(8'hF7));
    applyStimulus(8'hF0); applyStimulus(8'h29);

    applyStimulus(8'hE0);
    doReset();
    applyStimulus(8'h75);
    checkOutput("reset_drops_prefix", 64'(matrix[2*8+5]), 64'(1));
    applyStimulus(8'hF0); applyStimulus(8'h75);

    for (int n = 0; n < 400; n++) begin
      b = pool[$urandom_range(pool.size() - 1)];
      applyStimulus(b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_matrix_tracker.md
SCAN_MATRIX_TRACKER -- requirements
Module: scan_matrix_tracker

Interface
REQ-001 Parameter ROWS, default 8: keyboard matrix rows; legal range 2..8.
REQ-002 Parameter COLS, default 8: keyboard matrix columns; legal range 2..8.
REQ-003 Parameter SLOTS, default 4: simultaneously held mapped keys; legal range 1..8.
REQ-004 Port c, input, 1: clock; all state changes on posedge.
REQ-005 Port reset, input, 1: reset; synchronous and active-high.
REQ-006 Port scancode, input, 8: PS/2 set-2 byte.
REQ-007 Port scancode_valid, input, 1: one-cycle strobe qualifying scancode.
REQ-008 Port rowsel, input, ROWS: CPU row select; active-low.
REQ-009 Port colq, output, COLS: column sense for selected rows; active-low.
REQ-010 Port matrix, output, ROWS*COLS: key-down bitmap; bit index = row*COLS+col.
REQ-011 Port qshift, output, 1: effective Vector SS (shift) key state.
REQ-012 Port qerror, output, 1: one-cycle pulse on an unmapped make or a slot-table overflow.

Function
REQ-013 Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0).
- IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a make, return to IDLE.
- EXT: F0 goes to EXTBRK; other byte is an extended make, go to IDLE.
- BRK and EXTBRK: next byte is a break (extended in EXTBRK), go to IDLE.
REQ-014 Bytes with scancode_valid low are ignored; the FSM holds state indefinitely.
REQ-015 Physical shift (12, 59 non-extended): make sets shift_held, break clears it; never occupies a slot.
REQ-016 Other makes are translated by the lookup (scancode, ext, shift_held) into code[7:0].
- code[7] = shift-toggle.
- code[6:4] = row; code[2:0] = col.
- 8'hFF, or row >= ROWS, or col >= COLS = unmapped.
REQ-017 Unmapped make: no slot change; qerror pulses once.
REQ-018 Mapped make whose (scancode, ext) is already in a valid slot (typematic repeat): no change; no qerror.
REQ-019 Mapped new make: allocate the lowest free slot, storing scancode, ext, row, col and toggle.
- Row, col and toggle are captured at press time and are not re-evaluated.
- Slot becomes "last".
REQ-020 All slots full on a new mapped make: press dropped; qerror pulses.
REQ-021 Break: invalidate every valid slot matching (scancode, ext); a break with no match is silently ignored.
- If "last" is freed, last becomes none.
REQ-022 matrix is registered: bit set iff any valid slot holds that row/col; updates the cycle after the slot change.
- Byte strobed at edge N: slot changes at N+1, matrix at N+2.
REQ-023 colq[j] = NOT OR over rows r with rowsel[r]=0 of matrix[r*COLS+j]; combinational from matrix and rowsel.
REQ-024 qshift is registered: shift_held XOR toggle of "last" (XOR 0 when last is none).
REQ-025 Two keys mapping to the same row/col: bit stays set until both are released.

Reset
REQ-026 On reset: all slots invalid, last=none, FSM=IDLE, shift_held=0, matrix=0, qshift=0, qerror=0.
REQ-027 Reset overrides a coincident scancode_valid; a prefix in progress is discarded.

Configuration
REQ-028 Macro SCAN_MATRIX_EXT_EN controls extended-code support.
- Defined: E0 handling per REQ-013; extended cursor/Home/Del map via the lookup.
- Undefined: E0 is consumed and its following byte is discarded (FSM stays 3-state IDLE/BRK/discard); the ext field is absent from slots.

Structure
REQ-029 Shared package scan_matrix_pkg holds:
- code field positions and the UNMAPPED constant (8'hFF);
- prefix constants (E0, F0, LSHIFT 12, RSHIFT 59);
- the FSM state enum;
- the slot record typedef.
REQ-030 Sub-module scan_matrix_rom: combinational lookup (scancode, ext, shift) -> code; single instance.

Verification
REQ-031 Make 1C -> matrix bit 4*8+1 set at N+2; break F0 1C -> bit cleared.
REQ-032 Make 12 then 1E (shift 2) -> code C0, toggle=1, qshift=0; break 12 before 1E -> row 4 col 0 stays set until F0 1E.
REQ-033 Make 1C, 1B, 23, 2B, then 34 with SLOTS=4 -> qerror pulse, 34 not in matrix; break 1C then make 34 -> allocated.
REQ-034 Make 1C three times -> one slot used; single F0 1C clears.
REQ-035 E0 75 with SCAN_MATRIX_EXT_EN -> row 0 col 5 set; E0 F0 75 clears; without the macro -> matrix unchanged.
REQ-036 rowsel=8'hFD with row 1 col 3 held -> colq=8'hF7; reset asserted between E0 and 75 -> 75 treated as plain make.
